// File: rtl/shift_frame_ctrl.sv
// Frame sequencer driving load / enableShift / shiftClk for a chain of shiftRegs.
// Optional CRC-8 over the returning serial stream when SHIFT_FRAME_CRC_EN is defined.
module shift_frame_ctrl #(
    parameter int FRAME_BITS = 16,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       masterClk,
    input  logic       nReset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       shiftClk,
    output logic       enableShift,
    output logic       load,
    input  logic       serialIn,
    output logic [7:0] crc
);

    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(GAP_CYCLES);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS);
    localparam logic [GAP_W-1:0] GAP_DONE = GAP_W'(GAP_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        TRAIL,
        GAP
    } stateT;

    stateT            state, stateNxt;
    logic [DIV_W-1:0] divCnt, divNxt;
    logic [BIT_W-1:0] bitCnt, bitNxt;
    logic [GAP_W-1:0] gapCnt, gapNxt;
    logic             loadHalf, halfNxt;
    logic             busyNxt, doneNxt, clkNxt, enNxt, loadNxt;
    logic             sampleEn;
    logic             crcClear;

    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            divCnt      <= '0;
            bitCnt      <= '0;
            gapCnt      <= '0;
            loadHalf    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            shiftClk    <= 1'b0;
            enableShift <= 1'b0;
            load        <= 1'b0;
        end else begin
            state       <= stateNxt;
            divCnt      <= divNxt;
            bitCnt      <= bitNxt;
            gapCnt      <= gapNxt;
            loadHalf    <= halfNxt;
            busy        <= busyNxt;
            done        <= doneNxt;
            shiftClk    <= clkNxt;
            enableShift <= enNxt;
            load        <= loadNxt;
        end
    end

    // Next-state logic computes the following cycle's outputs so every output is a flop.
    // done is raised together with the return to IDLE so a held start re-triggers right after it.
    always_comb begin
        stateNxt = state;
        divNxt   = divCnt;
        bitNxt   = bitCnt;
        gapNxt   = gapCnt;
        halfNxt  = loadHalf;
        busyNxt  = busy;
        doneNxt  = 1'b0;
        clkNxt   = shiftClk;
        enNxt    = enableShift;
        loadNxt  = load;
        sampleEn = 1'b0;
        crcClear = 1'b0;

        case (state)
            IDLE: begin
                divNxt  = '0;
                bitNxt  = '0;
                gapNxt  = '0;
                halfNxt = 1'b0;
                if (start) begin
                    stateNxt = LOAD;
                    busyNxt  = 1'b1;
                    loadNxt  = 1'b1;
                    enNxt    = 1'b1;
                    clkNxt   = 1'b0;
                    crcClear = 1'b1;
                end
            end

            LOAD: begin
                if (divCnt == DIV_LAST) begin
                    divNxt = '0;
                    if (loadHalf) begin
                        stateNxt = SHIFT;
                        halfNxt  = 1'b0;
                        loadNxt  = 1'b0;
                        clkNxt   = 1'b1;
                        bitNxt   = BIT_W'(1);
                    end else begin
                        halfNxt = 1'b1;
                    end
                end else begin
                    divNxt = divCnt + DIV_W'(1);
                end
            end

            // A new rise is only issued while bits remain, so the frame never overshoots.
            SHIFT: begin
                if (divCnt == DIV_LAST) begin
                    divNxt = '0;
                    if (shiftClk) begin
                        clkNxt   = 1'b0;
                        sampleEn = 1'b1;
                    end else if (bitCnt == BIT_LAST) begin
                        stateNxt = TRAIL;
                    end else begin
                        clkNxt = 1'b1;
                        bitNxt = bitCnt + BIT_W'(1);
                    end
                end else begin
                    divNxt = divCnt + DIV_W'(1);
                end
            end

            TRAIL: begin
                if (divCnt == DIV_LAST) begin
                    divNxt   = '0;
                    stateNxt = GAP;
                    enNxt    = 1'b0;
                    gapNxt   = '0;
                end else begin
                    divNxt = divCnt + DIV_W'(1);
                end
            end

            GAP: begin
                if (gapCnt == GAP_DONE) begin
                    stateNxt = IDLE;
                    doneNxt  = 1'b1;
                    busyNxt  = 1'b0;
                    gapNxt   = '0;
                end else begin
                    gapNxt = gapCnt + GAP_W'(1);
                end
            end

            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

`ifdef SHIFT_FRAME_CRC_EN
    function automatic logic [7:0] crcStep(input logic [7:0] cur, input logic bitIn);
        logic fb;
        fb = cur[7] ^ bitIn;
        return {cur[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // MSB-first CRC-8 (poly 0x07); value persists after done until the next frame starts.
    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            crc <= 8'h00;
        end else if (crcClear) begin
            crc <= 8'h00;
        end else if (sampleEn) begin
            crc <= crcStep(crc, serialIn);
        end
    end
`else
    logic unusedCrcInputs;
    assign unusedCrcInputs = serialIn ^ sampleEn ^ crcClear;
    assign crc = 8'h00;
`endif

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Scoreboard bench for shift_frame_ctrl: default instance plus a minimal-size instance
// with a one-bit shadow shiftReg.
module tb_shift_frame_ctrl;

    localparam int FB   = 16;
    localparam int CD   = 4;
    localparam int GC   = 8;
    localparam int LEN  = 2 * CD * (FB + 1) + CD + GC;
    localparam int FB2  = 1;
    localparam int CD2  = 2;
    localparam int GC2  = 2;
    localparam int LEN2 = 2 * CD2 * (FB2 + 1) + CD2 + GC2;

`ifdef SHIFT_FRAME_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       masterClk = 1'b0;
    logic       nReset    = 1'b0;
    logic       start     = 1'b0;
    logic       serialIn  = 1'b0;
    logic       busy, done, shiftClk, enableShift, load;
    logic [7:0] crc;

    logic       start2 = 1'b0;
    logic       serialIn2;
    logic       busy2, done2, shiftClk2, enableShift2, load2;
    logic [7:0] crc2;

    shift_frame_ctrl #(.FRAME_BITS(FB), .CLK_DIV(CD), .GAP_CYCLES(GC)) uDut (
        .masterClk(masterClk), .nReset(nReset), .start(start), .busy(busy), .done(done),
        .shiftClk(shiftClk), .enableShift(enableShift), .load(load),
        .serialIn(serialIn), .crc(crc)
    );

    shift_frame_ctrl #(.FRAME_BITS(FB2), .CLK_DIV(CD2), .GAP_CYCLES(GC2)) uSmall (
        .masterClk(masterClk), .nReset(nReset), .start(start2), .busy(busy2), .done(done2),
        .shiftClk(shiftClk2), .enableShift(enableShift2), .load(load2),
        .serialIn(serialIn2), .crc(crc2)
    );

    always #5 masterClk = ~masterClk;

    int cyc = 0;
    always @(posedge masterClk) cyc <= cyc + 1;

    typedef struct {
        int         doneCyc;
        int         loadRiseCyc;
        logic [7:0] crc;
    } expT;

    expT sbQ[$];
    int  sb2Q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    logic [FB-1:0] pattern = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic pushExp(input int startCyc, input logic [7:0] handCrc);
        expT e;
        e.doneCyc     = startCyc + LEN;
        e.loadRiseCyc = startCyc + 1;
        e.crc         = CRC_ON ? handCrc : 8'h00;
        sbQ.push_back(e);
    endtask

    task automatic applyStimulus(input int holdCycles, input logic [FB-1:0] pat, input logic [7:0] handCrc);
        pattern = pat;
        start   = 1'b1;
        pushExp(cyc, handCrc);
        repeat (holdCycles) @(negedge masterClk);
        start = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((sbQ.size() != 0 || sb2Q.size() != 0) && n < budget) begin
            @(negedge masterClk);
            n++;
        end
        checkOutput("drain_timeout", 32'(sbQ.size() + sb2Q.size()), 0);
        sbQ.delete();
        sb2Q.delete();
    endtask

    // Serial data returning from the chain tail changes on each shiftClk rise.
    int   riseIdx    = 0;
    logic drvPrevClk = 1'b0;
    always @(negedge masterClk) begin
        if (load) begin
            riseIdx  = 0;
            serialIn = 1'b0;
        end else if (shiftClk && !drvPrevClk) begin
            serialIn = (riseIdx < FB) ? pattern[FB-1-riseIdx] : 1'b0;
            riseIdx++;
        end
        drvPrevClk = shiftClk;
    end

    int   riseCnt, loadCnt, enCnt, lastRiseAt, lastFallAt, enFallAt, minPer, maxPer, loadRiseAt;
    logic pClk = 1'b0, pEn = 1'b0, pLoad = 1'b0;

    always @(negedge masterClk) begin
        if (!nReset) begin
            pClk  = 1'b0;
            pEn   = 1'b0;
            pLoad = 1'b0;
        end else begin
            if (load && !pLoad) begin
                checkOutput("load_en_same_cycle", 32'(enableShift && !pEn), 1);
                loadRiseAt = cyc;
                riseCnt    = 0;
                loadCnt    = 0;
                enCnt      = 0;
                lastRiseAt = -1;
                minPer     = 1000000;
                maxPer     = 0;
            end
            if (load) loadCnt++;
            if (enableShift) enCnt++;
            if (shiftClk && !pClk) begin
                riseCnt++;
                if (lastRiseAt >= 0) begin
                    if (cyc - lastRiseAt < minPer) minPer = cyc - lastRiseAt;
                    if (cyc - lastRiseAt > maxPer) maxPer = cyc - lastRiseAt;
                end
                lastRiseAt = cyc;
            end
            if (!shiftClk && pClk) lastFallAt = cyc;
            if (!enableShift && pEn) enFallAt = cyc;
            if (done) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    expT e;
                    e = sbQ.pop_front();
                    checkOutput("done_cycle", 32'(cyc), 32'(e.doneCyc));
                    checkOutput("busy_at_done", 32'(busy), 0);
                    checkOutput("load_rise_cycle", 32'(loadRiseAt), 32'(e.loadRiseCyc));
                    checkOutput("shift_rises", 32'(riseCnt), FB);
                    checkOutput("load_cycles", 32'(loadCnt), 2 * CD);
                    checkOutput("enable_cycles", 32'(enCnt), LEN - GC);
                    checkOutput("period_min", 32'(minPer), 2 * CD);
                    checkOutput("period_max", 32'(maxPer), 2 * CD);
                    // last fall -> low half of final period -> trail half -> enableShift falls
                    checkOutput("en_fall_after_last_fall", 32'(enFallAt - lastFallAt), 2 * CD);
                    checkOutput("crc", 32'(crc), 32'(e.crc));
                end
            end
            pClk  = shiftClk;
            pEn   = enableShift;
            pLoad = load;
        end
    end

    // One-bit shadow shiftReg: loads 0, shifts in 1 on each rise, latches when enableShift falls.
    logic shadowReg = 1'b0, shadowLatch = 1'b0;
    logic pClk2 = 1'b0, pEn2 = 1'b0;
    int   rises2 = 0;
    assign serialIn2 = shadowReg;

    always @(negedge masterClk) begin
        if (!nReset) begin
            shadowReg   = 1'b0;
            shadowLatch = 1'b0;
            pClk2       = 1'b0;
            pEn2        = 1'b0;
            rises2      = 0;
        end else begin
            if (enableShift2 && !pEn2 && load2) begin
                shadowReg = 1'b0;
                rises2    = 0;
            end
            if (shiftClk2 && !pClk2) begin
                shadowReg = 1'b1;
                rises2++;
            end
            if (!enableShift2 && pEn2) shadowLatch = shadowReg;
            if (done2) begin
                if (sb2Q.size() == 0) begin
                    checkOutput("small_unexpected_done", 1, 0);
                end else begin
                    checkOutput("small_done_cycle", 32'(cyc), 32'(sb2Q.pop_front()));
                    checkOutput("small_rises", 32'(rises2), FB2);
                    checkOutput("small_shadow_latch", 32'(shadowLatch), 1);
                    checkOutput("small_crc", 32'(crc2), CRC_ON ? 32'h07 : 32'h00);
                end
            end
            pClk2 = shiftClk2;
            pEn2  = enableShift2;
        end
    end

    initial begin
        int c0;
        repeat (3) @(negedge masterClk);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_shiftClk", 32'(shiftClk), 0);
        checkOutput("reset_enableShift", 32'(enableShift), 0);
        checkOutput("reset_load", 32'(load), 0);
        checkOutput("reset_crc", 32'(crc), 0);
        #2 nReset = 1'b1;
        repeat (3) @(negedge masterClk);

        // T1 single frame; stream ...0011 gives crc 07 then 09
        applyStimulus(1, 16'h0003, 8'h09);
        waitDrain(400);
        repeat (5) @(negedge masterClk);

        // T2 start pulses inside the frame are ignored
        c0 = cyc;
        applyStimulus(1, 16'h0000, 8'h00);
        while (cyc < c0 + 20) @(negedge masterClk);
        start = 1'b1;
        @(negedge masterClk);
        start = 1'b0;
        while (cyc < c0 + 60) @(negedge masterClk);
        start = 1'b1;
        @(negedge masterClk);
        start = 1'b0;
        waitDrain(400);
        repeat (20) @(negedge masterClk);
        checkOutput("no_queued_frame_busy", 32'(busy), 0);

        // T3 start held high: second frame begins on the edge of the done cycle
        c0 = cyc;
        pattern = '0;
        start = 1'b1;
        pushExp(c0, 8'h00);
        pushExp(c0 + LEN, 8'h00);
        while (cyc < c0 + LEN + 5) @(negedge masterClk);
        start = 1'b0;
        waitDrain(600);
        repeat (5) @(negedge masterClk);

        // T4 reset during bit 7 of the shift phase
        applyStimulus(1, 16'hFFFF, 8'h00);
        repeat (CD * 2 + CD * 2 * 6 + 2) @(negedge masterClk);
        checkOutput("pre_reset_enableShift", 32'(enableShift), 1);
        #2 nReset = 1'b0;
        #1;
        checkOutput("mid_reset_busy", 32'(busy), 0);
        checkOutput("mid_reset_enableShift", 32'(enableShift), 0);
        checkOutput("mid_reset_shiftClk", 32'(shiftClk), 0);
        checkOutput("mid_reset_load", 32'(load), 0);
        checkOutput("mid_reset_crc", 32'(crc), 0);
        sbQ.delete();
        repeat (2) @(negedge masterClk);
        #2 nReset = 1'b1;
        repeat (LEN + 20) @(negedge masterClk);
        checkOutput("post_reset_idle_busy", 32'(busy), 0);

        // T5 full frame after reset; single trailing 1 gives crc 07
        applyStimulus(1, 16'h0001, 8'h07);
        waitDrain(400);
        repeat (5) @(negedge masterClk);

        // T6 minimal configuration
        start2 = 1'b1;
        sb2Q.push_back(cyc + LEN2);
        @(negedge masterClk);
        start2 = 1'b0;
        waitDrain(100);
        repeat (5) @(negedge masterClk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
